// File: rtl/pg_port_rst_pkg.sv
// rtl/pg_port_rst_pkg.sv - shared types and helpers for the port reset sequencer
//
// Purpose: per-port sequencer state encoding and the counter width helper.
// Ports:   none (package).
package pg_port_rst_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } t_pg_port_rst_state;

  // Width of the shared per-port counter: it must be able to reach the larger
  // of the drain budget and the reset hold length.
  function automatic int pg_rst_cnt_w(input int timeout, input int min_rst);
    int m;
    m = (timeout > min_rst) ? timeout : min_rst;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pg_port_rst_fsm.sv
// rtl/pg_port_rst_fsm.sv - single-port quiesce/drain/hold/release sequencer
//
// Purpose: sequences one PR-slot port through RUN -> DRAIN -> HOLD -> WAIT_REL
//          and back to RUN, with a shared saturating counter and a sticky
//          drain timeout flag.
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset (restarts the power-up sequence)
//   i_req          effective reset request for this port (level)
//   i_drain_done   port has no outstanding traffic (level)
//   i_err_clr      clears the sticky timeout flag
//   o_port_rst_n   active-low reset to the port
//   o_port_quiesce block new requests from the port
//   o_rst_done     one-cycle pulse on completion of a requested sequence
//   o_timeout_err  sticky; drain phase timed out
//   o_busy         port is not in RUN
module pg_port_rst_fsm
  import pg_port_rst_pkg::*;
#(
  parameter int MIN_RST_CYCLES = 16,
  parameter int DRAIN_TIMEOUT  = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_drain_done,
  input  logic i_err_clr,
  output logic o_port_rst_n,
  output logic o_port_quiesce,
  output logic o_rst_done,
  output logic o_timeout_err,
  output logic o_busy
);

  localparam int CNT_W = pg_rst_cnt_w(DRAIN_TIMEOUT, MIN_RST_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  t_pg_port_rst_state state;
  logic [CNT_W-1:0]   cnt;
  // Set by rst_n so the first trip through WAIT_REL releases without an ack.
  logic               pwr_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HOLD;
      cnt            <= '0;
      pwr_up         <= 1'b1;
      o_port_rst_n   <= 1'b0;
      o_port_quiesce <= 1'b1;
      o_rst_done     <= 1'b0;
      o_timeout_err  <= 1'b0;
    end else begin
      o_rst_done <= 1'b0;
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      // A timeout set later in this block overrides the clear.
      if (i_err_clr) begin
        o_timeout_err <= 1'b0;
      end

      unique case (state)
        RUN: begin
          if (i_req) begin
            cnt            <= '0;
            o_port_quiesce <= 1'b1;
            if (DRAIN_TIMEOUT == 0) begin
              state        <= HOLD;
              o_port_rst_n <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Drain-done takes priority: a port that drained on the last
          // allowed cycle did not time out.
          if (i_drain_done) begin
            state        <= HOLD;
            cnt          <= '0;
            o_port_rst_n <= 1'b0;
          end else if (cnt == DRAIN_LAST) begin
            state         <= HOLD;
            cnt           <= '0;
            o_port_rst_n  <= 1'b0;
            o_timeout_err <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= WAIT_REL;
            cnt   <= '0;
          end
        end
        WAIT_REL: begin
          if (!i_req) begin
            state          <= RUN;
            cnt            <= '0;
            o_port_rst_n   <= 1'b1;
            o_port_quiesce <= 1'b0;
            o_rst_done     <= ~pwr_up;
            pwr_up         <= 1'b0;
          end
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy = (state != RUN);

endmodule

// File: rtl/pg_port_rst_seq.sv
// rtl/pg_port_rst_seq.sv - per-port reset sequencer for the port gasket
//
// Purpose: one independent reset sequence per PR-slot port; a shared request
//          resets every port together.
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   i_sys_rst_req   request reset of all ports (level)
//   i_port_rst_req  per-port reset request (level)
//   i_drain_done    per-port no-outstanding-traffic indication
//   i_err_clr       clears all timeout flags
//   o_port_rst_n    per-port active-low reset
//   o_port_quiesce  per-port request block
//   o_rst_done      per-port completion pulse
//   o_timeout_err   per-port sticky drain timeout flag
//   o_busy          any port not in RUN
module pg_port_rst_seq #(
  parameter int NUM_PORTS      = 4,
  parameter int MIN_RST_CYCLES = 16,
  parameter int DRAIN_TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sys_rst_req,
  input  logic [NUM_PORTS-1:0] i_port_rst_req,
  input  logic [NUM_PORTS-1:0] i_drain_done,
  input  logic                 i_err_clr,
  output logic [NUM_PORTS-1:0] o_port_rst_n,
  output logic [NUM_PORTS-1:0] o_port_quiesce,
  output logic [NUM_PORTS-1:0] o_rst_done,
  output logic [NUM_PORTS-1:0] o_timeout_err,
  output logic                 o_busy
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] port_busy;

  assign req = i_port_rst_req | {NUM_PORTS{i_sys_rst_req}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    pg_port_rst_fsm #(
      .MIN_RST_CYCLES (MIN_RST_CYCLES),
      .DRAIN_TIMEOUT  (DRAIN_TIMEOUT)
    ) u_fsm (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req          (req[p]),
      .i_drain_done   (i_drain_done[p]),
      .i_err_clr      (i_err_clr),
      .o_port_rst_n   (o_port_rst_n[p]),
      .o_port_quiesce (o_port_quiesce[p]),
      .o_rst_done     (o_rst_done[p]),
      .o_timeout_err  (o_timeout_err[p]),
      .o_busy         (port_busy[p])
    );
  end

  assign o_busy = |port_busy;

endmodule

// File: tb/tb_pg_port_rst_seq.sv
// tb/tb_pg_port_rst_seq.sv - self-checking bench for pg_port_rst_seq
module tb_pg_port_rst_seq;

  localparam int NP = 4;
  localparam int MR = 16;
  localparam int DT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sys_req;
  logic [NP-1:0] preq, dd;
  logic          err_clr;
  logic [NP-1:0] a_rst_n, a_q, a_done, a_err;
  logic          a_busy;

  logic       b_sys, b_clr;
  logic [1:0] b_req, b_dd;
  logic [1:0] b_rst_n, b_q, b_done, b_err;
  logic       b_busy;

  pg_port_rst_seq #(.NUM_PORTS(NP), .MIN_RST_CYCLES(MR), .DRAIN_TIMEOUT(DT)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_sys_rst_req(sys_req), .i_port_rst_req(preq),
    .i_drain_done(dd), .i_err_clr(err_clr), .o_port_rst_n(a_rst_n),
    .o_port_quiesce(a_q), .o_rst_done(a_done), .o_timeout_err(a_err), .o_busy(a_busy));

  pg_port_rst_seq #(.NUM_PORTS(2), .MIN_RST_CYCLES(4), .DRAIN_TIMEOUT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_sys_rst_req(b_sys), .i_port_rst_req(b_req),
    .i_drain_done(b_dd), .i_err_clr(b_clr), .o_port_rst_n(b_rst_n),
    .o_port_quiesce(b_q), .o_rst_done(b_done), .o_timeout_err(b_err), .o_busy(b_busy));

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0=running,1=draining,2=held in reset,3=awaiting release;
  // m_n counts whole cycles already spent in the phase.
  int m_ph[NP];
  int m_n[NP];
  bit m_pwr[NP], m_err[NP], m_done[NP];

  typedef struct {
    logic [NP-1:0] preq;
    int            n;
    logic [NP-1:0] e_rst_n;
    logic [NP-1:0] e_q;
    logic [NP-1:0] e_done;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_ph[p] = 2; m_n[p] = 0; m_pwr[p] = 1; m_err[p] = 0; m_done[p] = 0;
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < NP; p++) begin
      bit r, es;
      r = preq[p] | sys_req;
      es = 0;
      m_done[p] = 0;
      case (m_ph[p])
        0: if (r) begin m_ph[p] = (DT == 0) ? 2 : 1; m_n[p] = 0; end
        1: begin
          m_n[p]++;
          if (dd[p]) begin m_ph[p] = 2; m_n[p] = 0; end
          else if (m_n[p] == DT) begin m_ph[p] = 2; m_n[p] = 0; es = 1; end
        end
        2: begin
          m_n[p]++;
          if (m_n[p] == MR) begin m_ph[p] = 3; m_n[p] = 0; end
        end
        default: if (!r) begin m_ph[p] = 0; m_done[p] = !m_pwr[p]; m_pwr[p] = 0; end
      endcase
      if (es) m_err[p] = 1;
      else if (err_clr) m_err[p] = 0;
    end
  endtask

  task automatic compare_model();
    logic [NP-1:0] er, eq, ed, ee;
    logic eb;
    eb = 0;
    for (int p = 0; p < NP; p++) begin
      er[p] = (m_ph[p] < 2);
      eq[p] = (m_ph[p] != 0);
      ed[p] = m_done[p];
      ee[p] = m_err[p];
      eb    = eb | (m_ph[p] != 0);
    end
    chk("model_rst_n", a_rst_n, er);
    chk("model_quiesce", a_q, eq);
    chk("model_done", a_done, ed);
    chk("model_err", a_err, ee);
    chk("model_busy", a_busy, eb);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    rst_n = 0; sys_req = 0; preq = '0; dd = '1; err_clr = 0;
    b_sys = 0; b_req = '0; b_dd = '0; b_clr = 0;
    model_reset();
    #22;
    chk("reset_rst_n", a_rst_n, 4'h0);
    chk("reset_quiesce", a_q, 4'hF);
    chk("reset_done", a_done, 4'h0);
    chk("reset_err", a_err, 4'h0);
    chk("reset_busy", a_busy, 1'b1);
    chk("reset_b_rst_n", b_rst_n, 2'b00);
    rst_n = 1;

    // Power-up: 16 HOLD cycles + 1 WAIT_REL, no ack.
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("pwrup_rst_n", a_rst_n, (i == 17) ? 4'hF : 4'h0);
      chk("pwrup_done", a_done, 4'h0);
    end
    chk("pwrup_busy", a_busy, 1'b0);
    chk("pwrup_b_rst_n", b_rst_n, 2'b11);
    repeat (3) step();

    // Port 2 one-cycle request with drain already done.
    tbl[0] = '{4'b0100, 1,  4'hF,    4'b0100, 4'h0};
    tbl[1] = '{4'b0000, 1,  4'b1011, 4'b0100, 4'h0};
    tbl[2] = '{4'b0000, 16, 4'b1011, 4'b0100, 4'h0};
    tbl[3] = '{4'b0000, 1,  4'hF,    4'h0,    4'b0100};
    tbl[4] = '{4'b0000, 3,  4'hF,    4'h0,    4'h0};
    for (int i = 0; i < 5; i++) begin
      preq = tbl[i].preq;
      for (int j = 0; j < tbl[i].n; j++) begin
        step();
        chk($sformatf("tbl%0d_rst_n", i), a_rst_n, tbl[i].e_rst_n);
        chk($sformatf("tbl%0d_quiesce", i), a_q, tbl[i].e_q);
        chk($sformatf("tbl%0d_done", i), a_done, tbl[i].e_done);
      end
    end

    // Port 1 drain timeout.
    dd = 4'b1101;
    preq = 4'b0010;
    step();
    chk("to_enter_drain", {a_q[1], a_rst_n[1]}, 2'b11);
    preq = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("to_still_drain", {a_q[1], a_rst_n[1]}, 2'b11);
    end
    step();
    chk("to_hold_rst_n", a_rst_n, 4'b1101);
    chk("to_err_set", a_err, 4'b0010);
    repeat (17) step();
    chk("to_back_run", a_rst_n, 4'hF);
    chk("to_err_sticky", a_err, 4'b0010);
    // New timeout with i_err_clr held through the whole drain.
    err_clr = 1;
    preq = 4'b0010;
    step();
    preq = 4'b0000;
    repeat (7) step();
    chk("to_err_cleared", a_err, 4'h0);
    step();
    chk("to_set_beats_clr", a_err, 4'b0010);
    err_clr = 0;
    step();
    chk("to_err_hold", a_err, 4'b0010);
    err_clr = 1;
    step();
    chk("to_err_clr", a_err, 4'h0);
    err_clr = 0;
    repeat (20) step();
    dd = 4'hF;

    // Shared request held 40 cycles.
    sys_req = 1;
    repeat (40) step();
    chk("sys_wait_rst_n", a_rst_n, 4'h0);
    chk("sys_wait_quiesce", a_q, 4'hF);
    chk("sys_wait_busy", a_busy, 1'b1);
    sys_req = 0;
    step();
    chk("sys_done_all", a_done, 4'hF);
    chk("sys_release", a_rst_n, 4'hF);
    step();
    chk("sys_done_pulse_only", a_done, 4'h0);

    // rst_n asserted while port 0 is in HOLD.
    preq = 4'b0001;
    step();
    preq = 4'b0000;
    repeat (5) step();
    chk("mid_in_hold", a_rst_n, 4'b1110);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_rst_n", a_rst_n, 4'h0);
    chk("mid_rst_quiesce", a_q, 4'hF);
    chk("mid_rst_done", a_done, 4'h0);
    chk("mid_rst_busy", a_busy, 1'b1);
    #2;
    rst_n = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("mid_pwrup_done", a_done, 4'h0);
    end
    chk("mid_pwrup_rst_n", a_rst_n, 4'hF);
    repeat (2) step();

    // Zero drain timeout: straight to HOLD, no error.
    b_req = 2'b01;
    step();
    chk("b_hold_now", b_rst_n, 2'b10);
    chk("b_quiesce", b_q, 2'b01);
    b_req = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("b_rst_n", b_rst_n, (i == 5) ? 2'b11 : 2'b10);
      chk("b_done", b_done, (i == 5) ? 2'b01 : 2'b00);
      chk("b_err", b_err, 2'b00);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 7) == 0) preq[p] = ~preq[p];
      if ($urandom_range(0, 63) == 0) sys_req = ~sys_req;
      dd = 4'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
